event_arbiter: RTL and testbench

- Consumer-side pop engine for `trigger_counter` and `fifo` instances.
- Sits between NUM_REQ upstream event sources, whose `pop_valid`/`pop_ready` feed `req_valid`/`req_ready`, and one downstream stage that executes one granted event per cycle.
- Selects one requester per cycle in round-robin order, pops it via `req_ready`, and presents the winner on a registered valid/ready output.
- Purpose: many sources can be triggered in one cycle, but only one grant is issued per cycle, and no source starves.

---
 rtl/event_arbiter.sv | 95 +++++++++
 tb/tb_event_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/event_arbiter.sv
// Round-robin pop engine: grants one pending event lane per cycle into a
// registered valid/ready output slot, popping the winner via req_ready_o.
module event_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic [NUM_REQ-1:0] grant_onehot_o,
    input  logic               grant_ready_i
);

    // One extra bit so last_grant + offset never overflows before the wrap.
    localparam int unsigned CAND_W = IDX_W + 1;

    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0] grant_onehot_q, grant_onehot_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;

    logic               pick_en_c;
    logic               any_req_c;
    logic               found_c;
    logic [IDX_W-1:0]   sel_c;
    logic [CAND_W-1:0]  cand_c;

    assign pick_en_c = !grant_valid_q || grant_ready_i;
    assign any_req_c = |req_valid_i;

    // Rotating scan starting just after the most recent winner.
    always_comb begin
        sel_c   = '0;
        found_c = 1'b0;
        cand_c  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = {1'b0, last_grant_q} + CAND_W'(k + 1);
            if (cand_c >= CAND_W'(NUM_REQ)) begin
                cand_c = cand_c - CAND_W'(NUM_REQ);
            end
            if (!found_c && req_valid_i[cand_c[IDX_W-1:0]]) begin
                found_c = 1'b1;
                sel_c   = cand_c[IDX_W-1:0];
            end
        end
    end

    // Pop strobe: only the winner, and only when the slot can take it.
    always_comb begin
        req_ready_o = '0;
        if (pick_en_c && any_req_c) begin
            req_ready_o = NUM_REQ'(1) << sel_c;
        end
    end

    always_comb begin
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        last_grant_d   = last_grant_q;
        if (pick_en_c) begin
            grant_valid_d = any_req_c;
            if (any_req_c) begin
                grant_idx_d    = sel_c;
                grant_onehot_d = NUM_REQ'(1) << sel_c;
                last_grant_d   = sel_c;
            end else begin
                // Index keeps its last value; the one-hot copy clears with valid.
                grant_onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            last_grant_q   <= IDX_W'(NUM_REQ - 1);
        end else begin
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign grant_valid_o  = grant_valid_q;
    assign grant_idx_o    = grant_idx_q;
    assign grant_onehot_o = grant_onehot_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter: vector table plus counter-driven and
// asynchronous-reset sequences.
module tb_event_arbiter;

    localparam int unsigned N = 4;

    typedef struct {
        logic [3:0] rv;
        logic       gr;
        logic [3:0] rr;
        logic       gv;
        logic [1:0] idx;
        logic [3:0] oh;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic [N-1:0] grant_onehot;
    logic         grant_ready;

    logic [N-1:0] rv_drv;
    logic         use_cnt;
    logic [3:0]   cnt [N];
    logic [3:0]   inc [N];
    logic [N-1:0] cnt_valid;

    int checks;
    int failures;
    vec_t vecs[$];

    event_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .grant_valid_o  (grant_valid),
        .grant_idx_o    (grant_idx),
        .grant_onehot_o (grant_onehot),
        .grant_ready_i  (grant_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal trigger_counter model: pending while count is non-zero.
    always_comb begin
        for (int i = 0; i < N; i++) cnt_valid[i] = (cnt[i] != 4'd0);
    end
    assign req_valid = use_cnt ? cnt_valid : rv_drv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < N; i++) cnt[i] <= cnt[i] + inc[i] - {3'd0, req_ready[i]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] rv, input logic gr, input logic [3:0] rr,
                       input logic gv, input logic [1:0] idx, input logic [3:0] oh);
        vec_t v;
        v.rv = rv; v.gr = gr; v.rr = rr; v.gv = gv; v.idx = idx; v.oh = oh;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rv_drv = '0;
        grant_ready = 1'b0;
        use_cnt = 1'b0;
        for (int i = 0; i < N; i++) inc[i] = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_seq [4];
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        rv_drv = '0;
        grant_ready = 1'b0;
        use_cnt = 1'b0;
        for (int i = 0; i < N; i++) inc[i] = 4'd0;

        // Idle, then full rotation, wrap/priority, backpressure, drain, stall.
        for (int i = 0; i < 5; i++) add(4'b0000, 1'(i % 2), 4'b0000, 1'b0, 2'd0, 4'b0000);
        add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001);
        add(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010);
        add(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100);
        add(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000);
        add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001);
        add(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010);
        add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b0000);
        add(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000);
        add(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000);
        add(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001);
        add(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000);
        add(4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001);
        for (int i = 0; i < 3; i++) add(4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0001);
        add(4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100);
        add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0000);
        add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0000);
        add(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010);
        add(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0010);
        add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'b0000);

        do_reset();
        #1;
        check("reset_gv", 32'(grant_valid), 32'd0);
        check("reset_idx", 32'(grant_idx), 32'd0);
        check("reset_oh", 32'(grant_onehot), 32'd0);
        check("reset_rr", 32'(req_ready), 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rv_drv = vecs[i].rv;
            grant_ready = vecs[i].gr;
            #1;
            check($sformatf("row%0d_rr", i), 32'(req_ready), 32'(vecs[i].rr));
            @(posedge clk);
            #1;
            check($sformatf("row%0d_gv", i), 32'(grant_valid), 32'(vecs[i].gv));
            check($sformatf("row%0d_idx", i), 32'(grant_idx), 32'(vecs[i].idx));
            check($sformatf("row%0d_oh", i), 32'(grant_onehot), 32'(vecs[i].oh));
        end

        // Counters: lane 1 += 3 and lane 2 += 1 in one cycle -> grants 1,2,1,1.
        do_reset();
        use_cnt = 1'b1;
        grant_ready = 1'b1;
        inc[1] = 4'd3;
        inc[2] = 4'd1;
        @(negedge clk);
        for (int i = 0; i < N; i++) inc[i] = 4'd0;
        #1;
        check("cnt_first_rr", 32'(req_ready), 32'b0010);
        exp_seq = '{1, 2, 1, 1};
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("cnt_gv%0d", k), 32'(grant_valid), 32'd1);
            check($sformatf("cnt_idx%0d", k), 32'(grant_idx), 32'(exp_seq[k]));
        end
        @(posedge clk);
        #1;
        check("cnt_drained_gv", 32'(grant_valid), 32'd0);
        check("cnt_lane1_empty", 32'(cnt[1]), 32'd0);
        check("cnt_lane2_empty", 32'(cnt[2]), 32'd0);
        use_cnt = 1'b0;

        // Asynchronous reset while a grant is held, then lane 0 wins first.
        do_reset();
        rv_drv = 4'b0010;
        grant_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ar_pre_gv", 32'(grant_valid), 32'd1);
        check("ar_pre_idx", 32'(grant_idx), 32'd1);
        grant_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gv", 32'(grant_valid), 32'd0);
        check("ar_idx", 32'(grant_idx), 32'd0);
        check("ar_oh", 32'(grant_onehot), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv_drv = 4'b1111;
        grant_ready = 1'b1;
        #1;
        check("ar_post_rr", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        check("ar_post_idx", 32'(grant_idx), 32'd0);
        check("ar_post_gv", 32'(grant_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
